// File: rtl/fetch_r32i.sv
//==============================================================================
// Module   : fetch_r32i
// Purpose  : RISCV32I instruction fetch stage. Samples the PC, issues word
//            reads to program memory over a req/ack handshake and buffers the
//            returned instructions in a 2-entry FIFO for decode.
//            Taken-branch flushes discard buffered and in-flight instructions.
// Revision : 1.0 - initial release
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   ProgAddr    in   current PC
//   Flush       in   taken-branch pulse (PC loads target on the same edge)
//   PCAdvance   out  combinational; PC steps by 4 on this edge
//   MemReq      out  registered read request
//   MemAddr     out  registered word-aligned read address
//   MemAck      in   request accepted, MemData valid this cycle
//   MemData     in   returned instruction word
//   InstrValid  out  FIFO head valid
//   InstrReady  in   decode accepts the head
//   Instr       out  FIFO head instruction
//   InstrAddr   out  address of Instr
//   FetchFault  out  sticky misaligned-fetch flag
//
// Build option
//   FETCH_MISALIGN_CHECK_EN : when defined, a misaligned PC seen in IDLE sets
//                             FetchFault and blocks further requests. When
//                             undefined, ProgAddr[1:0] is ignored and
//                             FetchFault is tied low.
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module fetch_r32i #(
  parameter int dataW = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [dataW-1:0] ProgAddr,
  input  logic             Flush,
  output logic             PCAdvance,
  output logic             MemReq,
  output logic [dataW-1:0] MemAddr,
  input  logic             MemAck,
  input  logic [dataW-1:0] MemData,
  output logic             InstrValid,
  input  logic             InstrReady,
  output logic [dataW-1:0] Instr,
  output logic [dataW-1:0] InstrAddr,
  output logic             FetchFault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t           state;
  logic             fault;
  logic             misaligned;
  logic             issue;
  logic             push;
  logic             pop;

  // FIFO storage: address and instruction per entry
  logic [dataW-1:0] fifo_addr [2];
  logic [dataW-1:0] fifo_data [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misaligned = (ProgAddr[1:0] != 2'b00);
`else
  logic unused_pc_low;
  assign misaligned    = 1'b0;
  assign unused_pc_low = ^ProgAddr[1:0];
`endif

  // Only IDLE issues, so nothing is in flight when count is compared here;
  // a returning word can therefore never find the FIFO full.
  assign issue = (state == IDLE) && !Flush && !fault && !misaligned && (count < 2'd2);

  // A flush in the ack cycle kills both the push and the PC step.
  assign PCAdvance = (state == WAIT) && MemAck && !Flush;
  assign push      = PCAdvance;
  assign pop       = InstrValid && InstrReady;

  //--------------------------------------------------------------------------
  // Request FSM
  //--------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      MemReq  <= 1'b0;
      MemAddr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            MemAddr <= {ProgAddr[dataW-1:2], 2'b00};
            MemReq  <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          // Ack ends the transaction whether or not it is flushed; a flush
          // without ack must still wait out the memory in DROP.
          if (MemAck) begin
            MemReq <= 1'b0;
            state  <= IDLE;
          end else if (Flush) begin
            state  <= DROP;
          end
        end
        DROP: begin
          if (MemAck) begin
            MemReq <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          MemReq <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  //--------------------------------------------------------------------------
  // Sticky misaligned-fetch fault
  //--------------------------------------------------------------------------
`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fault <= 1'b0;
    end else if ((state == IDLE) && !Flush && misaligned) begin
      fault <= 1'b1;
    end
  end
`else
  assign fault = 1'b0;
`endif

  assign FetchFault = fault;

  //--------------------------------------------------------------------------
  // 2-entry instruction FIFO
  //--------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_addr[i] <= '0;
        fifo_data[i] <= '0;
      end
    end else if (Flush) begin
      // Flush wins over any same-cycle push or pop.
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_addr[wr_ptr] <= MemAddr;
        fifo_data[wr_ptr] <= MemData;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Head outputs come straight from registers; InstrReady only affects
  // the next-state pointers.
  assign InstrValid = (count != 2'd0);
  assign Instr      = fifo_data[rd_ptr];
  assign InstrAddr  = fifo_addr[rd_ptr];

endmodule

`default_nettype wire

// File: tb/tb_fetch_r32i.sv
//==============================================================================
// Module   : tb_fetch_r32i
// Purpose  : Self-checking bench for fetch_r32i. Directed scenarios push the
//            expected request addresses and instruction words into queues;
//            a negedge monitor pops and compares whenever the DUT presents an
//            accepted request or a consumed instruction. A small PC model and
//            memory responder form the environment around the DUT.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fetch_r32i;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ProgAddr = 32'h0;
  logic        Flush = 1'b0;
  logic        PCAdvance;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck = 1'b0;
  logic [31:0] MemData = 32'h0;
  logic        InstrValid;
  logic        InstrReady = 1'b0;
  logic [31:0] Instr;
  logic [31:0] InstrAddr;
  logic        FetchFault;

  int          vectors = 0;
  int          miscompares = 0;
  int          pcadv_cnt = 0;
  int          ack_delay = 0;
  int          req_cycles = 0;
  bit          mem_en = 1'b0;
  bit          adv_c = 1'b0;
  bit          fl_c = 1'b0;
  logic [31:0] flush_target = 32'h0;

  logic [31:0] exp_req [$];
  logic [63:0] exp_instr [$];

  fetch_r32i #(.dataW(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .ProgAddr   (ProgAddr),
    .Flush      (Flush),
    .PCAdvance  (PCAdvance),
    .MemReq     (MemReq),
    .MemAddr    (MemAddr),
    .MemAck     (MemAck),
    .MemData    (MemData),
    .InstrValid (InstrValid),
    .InstrReady (InstrReady),
    .Instr      (Instr),
    .InstrAddr  (InstrAddr),
    .FetchFault (FetchFault)
  );

  always #5 clock = ~clock;

  // Program memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, 16'h0013};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // Monitor: sampled mid-cycle, well away from the active edge.
  always @(negedge clock) begin
    if (reset) begin
      adv_c = PCAdvance;
      fl_c  = Flush;
      if (PCAdvance) pcadv_cnt++;
      if (MemReq && MemAck) begin
        if (exp_req.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL req_extra: got addr %0h expected no request", MemAddr);
        end else begin
          check("mem_addr", {32'h0, MemAddr}, {32'h0, exp_req.pop_front()});
        end
      end
      if (InstrValid && InstrReady) begin
        if (exp_instr.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL instr_extra: got %0h/%0h expected none", InstrAddr, Instr);
        end else begin
          check("instr", {InstrAddr, Instr}, exp_instr.pop_front());
        end
      end
    end else begin
      adv_c = 1'b0;
      fl_c  = 1'b0;
    end
  end

  // Environment: PC register upstream and program memory downstream.
  always @(posedge clock) begin
    #3;
    if (reset) begin
      if (fl_c)       ProgAddr = flush_target;
      else if (adv_c) ProgAddr = ProgAddr + 32'd4;
    end
    if (reset && MemReq && mem_en) begin
      MemAck = (req_cycles == ack_delay);
      req_cycles++;
    end else begin
      MemAck     = 1'b0;
      req_cycles = 0;
    end
    MemData = MemAck ? data_of(MemAddr) : 32'h0;
  end

  task automatic do_reset(input logic [31:0] pc);
    reset      = 1'b0;
    mem_en     = 1'b0;
    Flush      = 1'b0;
    InstrReady = 1'b0;
    ProgAddr   = pc;
    exp_req.delete();
    exp_instr.delete();
    step();
    step();
    pcadv_cnt = 0;
    reset     = 1'b1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_req.size() == 0 && exp_instr.size() == 0) break;
      step();
    end
    if (exp_req.size() != 0 || exp_instr.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d/%0d pending expected 0/0",
               exp_req.size(), exp_instr.size());
    end
  endtask

  task automatic wait_req(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (MemReq) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL req_timeout: got MemReq 0 expected 1 within %0d cycles", budget);
    end
  endtask

  task automatic push_pair(input logic [31:0] a);
    exp_instr.push_back({a, data_of(a)});
  endtask

  initial begin
    // ---- reset values
    step();
    step();
    check("rst_memreq",  {63'h0, MemReq},     64'h0);
    check("rst_memaddr", {32'h0, MemAddr},    64'h0);
    check("rst_valid",   {63'h0, InstrValid}, 64'h0);
    check("rst_instr",   {32'h0, Instr},      64'h0);
    check("rst_iaddr",   {32'h0, InstrAddr},  64'h0);
    check("rst_fault",   {63'h0, FetchFault}, 64'h0);
    check("rst_pcadv",   {63'h0, PCAdvance},  64'h0);

    // ---- zero-wait memory, decode always ready: 0,4,8 one per two cycles
    do_reset(32'h0);
    ack_delay = 0; mem_en = 1'b1; InstrReady = 1'b1;
    exp_req.push_back(32'h0); exp_req.push_back(32'h4); exp_req.push_back(32'h8);
    push_pair(32'h0); push_pair(32'h4); push_pair(32'h8);
    step();
    check("t1_req_e0",  {63'h0, MemReq},     64'h1);
    check("t1_addr_e0", {32'h0, MemAddr},    64'h0);
    step();
    check("t1_valid_e1", {63'h0, InstrValid}, 64'h1);
    check("t1_instr_e1", {32'h0, Instr},      {32'h0, 32'h5A5A0013});
    repeat (4) step();
    mem_en = 1'b0;
    drain(10);
    check("t1_pcadv", pcadv_cnt, 64'd3);

    // ---- decode stalled: two fetches then stop, resume on ready
    do_reset(32'h0);
    ack_delay = 0; mem_en = 1'b1; InstrReady = 1'b0;
    exp_req.push_back(32'h0); exp_req.push_back(32'h4); exp_req.push_back(32'h8);
    push_pair(32'h0); push_pair(32'h4); push_pair(32'h8);
    repeat (8) step();
    check("t2_req_stalled", {63'h0, MemReq},     64'h0);
    check("t2_valid",       {63'h0, InstrValid}, 64'h1);
    check("t2_head_addr",   {32'h0, InstrAddr},  64'h0);
    check("t2_pcadv_2",     pcadv_cnt,           64'd2);
    InstrReady = 1'b1;
    repeat (3) step();
    mem_en = 1'b0;
    drain(10);
    check("t2_pcadv_3", pcadv_cnt, 64'd3);

    // ---- flush in second wait cycle of a delayed fetch of address 8
    do_reset(32'h0);
    ack_delay = 0; mem_en = 1'b1; InstrReady = 1'b0;
    exp_req.push_back(32'h0); exp_req.push_back(32'h4);
    exp_req.push_back(32'h8); exp_req.push_back(32'h100);
    push_pair(32'h0); push_pair(32'h100);
    repeat (6) step();
    ack_delay = 3; InstrReady = 1'b1;
    step();
    InstrReady = 1'b0;
    wait_req(10);
    check("t3_addr_8", {32'h0, MemAddr}, 64'h8);
    step();
    Flush = 1'b1; flush_target = 32'h100;
    step();
    Flush = 1'b0;
    check("t3_valid_flushed", {63'h0, InstrValid}, 64'h0);
    check("t3_drop_req_held", {63'h0, MemReq},     64'h1);
    InstrReady = 1'b1;
    drain(20);
    mem_en = 1'b0;
    check("t3_pcadv", pcadv_cnt, 64'd3);

    // ---- flush in the same cycle as the ack
    do_reset(32'h40);
    ack_delay = 2; mem_en = 1'b1; InstrReady = 1'b1;
    exp_req.push_back(32'h40); exp_req.push_back(32'h200);
    push_pair(32'h200);
    wait_req(10);
    step();
    step();
    Flush = 1'b1; flush_target = 32'h200;
    #2;
    check("t4_ack_seen",     {63'h0, MemAck},    64'h1);
    check("t4_pcadv_killed", {63'h0, PCAdvance}, 64'h0);
    step();
    Flush = 1'b0;
    drain(20);
    mem_en = 1'b0;
    check("t4_pcadv", pcadv_cnt, 64'd1);

    // ---- asynchronous reset mid-WAIT, then restart from a new PC
    do_reset(32'h0);
    ack_delay = 0; mem_en = 1'b1; InstrReady = 1'b0;
    exp_req.push_back(32'h0);
    step();
    step();
    ack_delay = 5;
    wait_req(10);
    reset = 1'b0;
    #1;
    check("t5_rst_memreq", {63'h0, MemReq},     64'h0);
    check("t5_rst_valid",  {63'h0, InstrValid}, 64'h0);
    check("t5_rst_fault",  {63'h0, FetchFault}, 64'h0);
    do_reset(32'h300);
    ack_delay = 0; mem_en = 1'b1; InstrReady = 1'b1;
    exp_req.push_back(32'h300);
    push_pair(32'h300);
    step();
    step();
    mem_en = 1'b0;
    drain(10);
    check("t5_pcadv", pcadv_cnt, 64'd1);

    // ---- misaligned PC
    do_reset(32'h102);
    ack_delay = 0; mem_en = 1'b1; InstrReady = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
    repeat (3) step();
    check("t6_fault",    {63'h0, FetchFault}, 64'h1);
    check("t6_no_req",   {63'h0, MemReq},     64'h0);
    Flush = 1'b1; flush_target = 32'h200;
    step();
    Flush = 1'b0;
    repeat (3) step();
    check("t6_fault_sticky", {63'h0, FetchFault}, 64'h1);
    check("t6_no_req_after", {63'h0, MemReq},     64'h0);
    check("t6_pcadv",        pcadv_cnt,           64'd0);
    mem_en = 1'b0;
`else
    exp_req.push_back(32'h100);
    push_pair(32'h100);
    step();
    step();
    mem_en = 1'b0;
    drain(10);
    check("t6_no_fault", {63'h0, FetchFault}, 64'h0);
    check("t6_pcadv",    pcadv_cnt,           64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
